// File: rtl/vj_scan_ctrl.sv
// vj_scan_ctrl: scan-window scheduler for the Viola-Jones detection pipeline.
//
// Walks a WINDOW_SIZE x WINDOW_SIZE window across one integral-image pyramid level in
// raster order. Each origin is offered to the window loader through a valid/ready handshake
// and remembered in an in-order origin FIFO. Every classifier result pops that FIFO. Results
// that pass the cascade have their origin pushed into a face FIFO, which drives the output
// stream.
//
// Ports:
//   clock, rst_n           clock (rising edge), asynchronous active-low reset
//   start                  begin a scan (sampled only in IDLE)
//   busy, done             scan in progress; one-cycle completion pulse
//   win_valid/ready/x/y    window origin issue handshake
//   res_valid, res_face    in-order classifier result (cannot be stalled)
//   face_valid/ready/x/y   detected face output stream
//   overflow               sticky: a face was dropped on a full face FIFO; cleared on start
//   face_count, drop_count saturating statistics (only when VJ_SCAN_STATS_EN is defined)
//
// Optional feature macro: VJ_SCAN_STATS_EN builds the face_count / drop_count ports and their
// registers. Without it those ports and registers are absent; everything else is identical.

module vj_scan_ctrl #(
   parameter int unsigned IMG_WIDTH   = 40,
   parameter int unsigned IMG_HEIGHT  = 30,
   parameter int unsigned WINDOW_SIZE = 24,
   parameter int unsigned STEP        = 1,
   parameter int unsigned PIPE_DEPTH  = 8,
   parameter int unsigned OUT_DEPTH   = 4,
   parameter int unsigned COORD_W     = 16
) (
   input  logic               clock,
   input  logic               rst_n,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               win_valid,
   input  logic               win_ready,
   output logic [COORD_W-1:0] win_x,
   output logic [COORD_W-1:0] win_y,
   input  logic               res_valid,
   input  logic               res_face,
   output logic               face_valid,
   input  logic               face_ready,
   output logic [COORD_W-1:0] face_x,
   output logic [COORD_W-1:0] face_y,
   output logic               overflow
`ifdef VJ_SCAN_STATS_EN
   ,
   output logic [15:0]        face_count,
   output logic [15:0]        drop_count
`endif
);

   localparam int unsigned XMax  = IMG_WIDTH - WINDOW_SIZE;
   localparam int unsigned YMax  = IMG_HEIGHT - WINDOW_SIZE;
   localparam int unsigned PtrW  = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
   localparam int unsigned CntW  = $clog2(PIPE_DEPTH + 1);
   localparam int unsigned FPtrW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int unsigned FCntW = $clog2(OUT_DEPTH + 1);

   // One extra bit so x+STEP / y+STEP cannot wrap before the limit compare.
   localparam logic [COORD_W:0]   StepW = (COORD_W + 1)'(STEP);
   localparam logic [COORD_W:0]   XMaxW = (COORD_W + 1)'(XMax);
   localparam logic [COORD_W:0]   YMaxW = (COORD_W + 1)'(YMax);
   localparam logic [COORD_W-1:0] StepC = COORD_W'(STEP);

   typedef enum logic [1:0] {StIdle, StScan, StDrain, StFlush} state_e;

   state_e             state;
   logic [COORD_W-1:0] x, y;

   // Origin FIFO (in-flight windows, in issue order).
   logic [2*COORD_W-1:0] omem [PIPE_DEPTH];
   logic [PtrW-1:0]      owr, ord;
   logic [CntW-1:0]      ocnt;
   logic                 opush, opop;
   logic [2*COORD_W-1:0] pop_org;

   // Face FIFO (detected origins awaiting the consumer).
   logic [2*COORD_W-1:0] fmem [OUT_DEPTH];
   logic [FPtrW-1:0]     fwr, frd;
   logic [FCntW-1:0]     fcnt;
   logic                 fpop, fpush_req, faccept, fdrop;

   logic x_wrap, y_last;

   assign x_wrap = ({1'b0, x} + StepW) > XMaxW;
   assign y_last = ({1'b0, y} + StepW) > YMaxW;

   // Issue depends only on registered state: no path from win_ready or res_valid.
   assign busy      = (state != StIdle);
   assign win_valid = (state == StScan) && (ocnt < CntW'(PIPE_DEPTH));
   assign win_x     = x;
   assign win_y     = y;

   assign opush   = win_valid && win_ready;
   assign opop    = res_valid && (ocnt != '0);  // result with nothing in flight is ignored
   assign pop_org = omem[ord];

   assign face_valid = (fcnt != '0);
   assign face_x     = face_valid ? fmem[frd][2*COORD_W-1:COORD_W] : '0;
   assign face_y     = face_valid ? fmem[frd][COORD_W-1:0] : '0;

   // A full face FIFO still accepts a push when the consumer pops in the same cycle.
   assign fpop      = face_valid && face_ready;
   assign fpush_req = opop && res_face;
   assign faccept   = fpush_req && ((fcnt < FCntW'(OUT_DEPTH)) || fpop);
   assign fdrop     = fpush_req && !faccept;

   // Control FSM with registered done / overflow.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state    <= StIdle;
         x        <= '0;
         y        <= '0;
         done     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         if (fdrop) begin
            overflow <= 1'b1;
         end
         unique case (state)
            StIdle: begin
               if (start) begin
                  x        <= '0;
                  y        <= '0;
                  overflow <= 1'b0;
                  state    <= StScan;
               end
            end
            StScan: begin
               if (opush) begin
                  if (x_wrap) begin
                     x <= '0;
                     y <= y + StepC;
                     if (y_last) begin
                        state <= StDrain;
                     end
                  end else begin
                     x <= x + StepC;
                  end
               end
            end
            StDrain: begin
               if (ocnt == '0) begin
                  state <= StFlush;
               end
            end
            StFlush: begin
               if (fcnt == '0) begin
                  done  <= 1'b1;
                  state <= StIdle;
               end
            end
         endcase
      end
   end

   // Origin FIFO pointers and occupancy; push+pop in one cycle leaves the count unchanged.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         owr  <= '0;
         ord  <= '0;
         ocnt <= '0;
      end else begin
         if (opush) begin
            owr <= (owr == PtrW'(PIPE_DEPTH - 1)) ? '0 : owr + 1'b1;
         end
         if (opop) begin
            ord <= (ord == PtrW'(PIPE_DEPTH - 1)) ? '0 : ord + 1'b1;
         end
         ocnt <= ocnt + CntW'(opush) - CntW'(opop);
      end
   end

   always_ff @(posedge clock) begin
      if (opush) begin
         omem[owr] <= {x, y};
      end
   end

   // Face FIFO pointers and occupancy.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         fwr  <= '0;
         frd  <= '0;
         fcnt <= '0;
      end else begin
         if (faccept) begin
            fwr <= (fwr == FPtrW'(OUT_DEPTH - 1)) ? '0 : fwr + 1'b1;
         end
         if (fpop) begin
            frd <= (frd == FPtrW'(OUT_DEPTH - 1)) ? '0 : frd + 1'b1;
         end
         fcnt <= fcnt + FCntW'(faccept) - FCntW'(fpop);
      end
   end

   always_ff @(posedge clock) begin
      if (faccept) begin
         fmem[fwr] <= pop_org;
      end
   end

`ifdef VJ_SCAN_STATS_EN
   // Saturating statistics, cleared together with overflow when a scan starts.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         face_count <= '0;
         drop_count <= '0;
      end else if ((state == StIdle) && start) begin
         face_count <= '0;
         drop_count <= '0;
      end else begin
         if (faccept && (face_count != 16'hFFFF)) begin
            face_count <= face_count + 16'd1;
         end
         if (fdrop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_vj_scan_ctrl.sv
// tb_vj_scan_ctrl: self-checking bench for vj_scan_ctrl.
//
// A 26x26 level with a 24-pixel window (3x3 origins), PIPE_DEPTH=4, OUT_DEPTH=2. The reference
// model keeps the expected raster list of origins, a queue of in-flight window indices and a
// queue of pending faces; DUT outputs are compared against it every cycle, plus directed
// end-of-scenario checks.

module tb_vj_scan_ctrl;

   localparam int unsigned ImgW  = 26;
   localparam int unsigned ImgH  = 26;
   localparam int unsigned Win   = 24;
   localparam int unsigned Step  = 1;
   localparam int unsigned PDep  = 4;
   localparam int unsigned ODep  = 2;
   localparam int unsigned CW    = 16;

   logic          clock, rst_n, start;
   logic          busy, done, win_valid, win_ready;
   logic [CW-1:0] win_x, win_y, face_x, face_y;
   logic          res_valid, res_face, face_valid, face_ready, overflow;
`ifdef VJ_SCAN_STATS_EN
   logic [15:0]   face_count, drop_count;
`endif

   vj_scan_ctrl #(
      .IMG_WIDTH  (ImgW),
      .IMG_HEIGHT (ImgH),
      .WINDOW_SIZE(Win),
      .STEP       (Step),
      .PIPE_DEPTH (PDep),
      .OUT_DEPTH  (ODep),
      .COORD_W    (CW)
   ) dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .win_valid (win_valid),
      .win_ready (win_ready),
      .win_x     (win_x),
      .win_y     (win_y),
      .res_valid (res_valid),
      .res_face  (res_face),
      .face_valid(face_valid),
      .face_ready(face_ready),
      .face_x    (face_x),
      .face_y    (face_y),
      .overflow  (overflow)
`ifdef VJ_SCAN_STATS_EN
      ,
      .face_count(face_count),
      .drop_count(drop_count)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
   } org_t;

   typedef enum int {MIdle, MScan, MDrain, MFlush} mph_t;

   org_t        olist[$];
   int          inflq[$];
   org_t        fq[$];
   mph_t        ph;
   int unsigned next_idx;
   bit          m_done, m_ovf;
   int unsigned m_faces, m_drops;

   int unsigned n_vec, n_err;
   int unsigned n_xfer_obs, n_done_obs;
   org_t        got_faces[$];
   bit          prev_stall;
   logic [15:0] px, py;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      ph       = MIdle;
      next_idx = 0;
      inflq.delete();
      fq.delete();
      m_done   = 0;
      m_ovf    = 0;
      m_faces  = 0;
      m_drops  = 0;
      prev_stall = 0;
   endtask

   task automatic chk_reset_values();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_win_valid", win_valid, 0);
      chk("rst_win_x", win_x, 0);
      chk("rst_win_y", win_y, 0);
      chk("rst_face_valid", face_valid, 0);
      chk("rst_face_x", face_x, 0);
      chk("rst_face_y", face_y, 0);
      chk("rst_overflow", overflow, 0);
`ifdef VJ_SCAN_STATS_EN
      chk("rst_face_count", face_count, 0);
      chk("rst_drop_count", drop_count, 0);
`endif
   endtask

   task automatic check_outputs();
      bit   exp_wv;
      org_t o;
      exp_wv = (ph == MScan) && (inflq.size() < PDep);
      chk("busy", busy, ph != MIdle);
      chk("done", done, m_done);
      chk("win_valid", win_valid, exp_wv);
      if (exp_wv) begin
         o = olist[next_idx];
         chk("win_x", win_x, o.x);
         chk("win_y", win_y, o.y);
      end
      if (prev_stall) begin
         chk("stall_win_x", win_x, px);
         chk("stall_win_y", win_y, py);
      end
      chk("face_valid", face_valid, fq.size() > 0);
      if (fq.size() > 0) begin
         chk("face_x", face_x, fq[0].x);
         chk("face_y", face_y, fq[0].y);
      end
      chk("overflow", overflow, m_ovf);
`ifdef VJ_SCAN_STATS_EN
      chk("face_count", face_count, m_faces);
      chk("drop_count", drop_count, m_drops);
`endif
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      bit xfer, rv, fp;
      int isz, fsz, idx;
      isz    = inflq.size();
      fsz    = fq.size();
      xfer   = (ph == MScan) && (isz < PDep) && win_ready;
      rv     = res_valid && (isz > 0);
      fp     = (fsz > 0) && face_ready;
      m_done = 0;
      if (fp) void'(fq.pop_front());
      if (rv) begin
         idx = inflq.pop_front();
         if (res_face) begin
            if (fsz < ODep || fp) begin
               fq.push_back(olist[idx]);
               if (m_faces < 16'hFFFF) m_faces++;
            end else begin
               m_ovf = 1;
               if (m_drops < 16'hFFFF) m_drops++;
            end
         end
      end
      case (ph)
         MIdle: if (start) begin
            ph = MScan; next_idx = 0; m_ovf = 0; m_faces = 0; m_drops = 0;
         end
         MScan: if (xfer) begin
            inflq.push_back(next_idx);
            next_idx++;
            if (next_idx == olist.size()) ph = MDrain;
         end
         MDrain: if (isz == 0) ph = MFlush;
         MFlush: if (fsz == 0) begin ph = MIdle; m_done = 1; end
         default: ;
      endcase
   endtask

   // One clock: compare, record observed handshakes, advance model, move to next sample point.
   task automatic cycle();
      org_t f;
      check_outputs();
      if (win_valid && win_ready) n_xfer_obs++;
      if (done) n_done_obs++;
      if (face_valid && face_ready) begin
         f.x = face_x;
         f.y = face_y;
         got_faces.push_back(f);
      end
      prev_stall = win_valid && !win_ready;
      px = win_x;
      py = win_y;
      model_step();
      @(posedge clock);
      #1;
   endtask

   function automatic bit head_is(input int k);
      return (inflq.size() > 0) && (inflq[0] == k);
   endfunction

   task automatic set_inputs(input int mode);
      case (mode)
         0: begin  // full throughput, faces on windows 2 and 7
            start = 0; win_ready = 1; res_valid = 1; face_ready = 1;
            res_face = head_is(2) || head_is(7);
         end
         1: begin  // everything a face, consumer stalled
            start = 0; win_ready = 1; res_valid = 1'($urandom_range(0, 1));
            res_face = 1; face_ready = 0;
         end
         2: begin  // win_ready toggles every cycle, start pokes while busy
            start = 1'($urandom_range(0, 1)); win_ready = !win_ready;
            res_valid = 1'($urandom_range(0, 1)); res_face = 1'($urandom_range(0, 1));
            face_ready = 1'($urandom_range(0, 1));
         end
         default: begin
            start = 0; win_ready = 1'($urandom_range(0, 1));
            res_valid = 1'($urandom_range(0, 1)); res_face = 1'($urandom_range(0, 1));
            face_ready = 1'($urandom_range(0, 1));
         end
      endcase
   endtask

   task automatic idle_inputs();
      start = 0; win_ready = 0; res_valid = 0; res_face = 0; face_ready = 0;
   endtask

   task automatic begin_scan();
      idle_inputs();
      start = 1;
      cycle();
      start = 0;
      n_xfer_obs = 0;
      n_done_obs = 0;
      got_faces.delete();
   endtask

   task automatic run_to_idle(input int mode, input int bound);
      for (int i = 0; i < bound && ph != MIdle; i++) begin
         set_inputs(mode);
         cycle();
      end
      idle_inputs();
      cycle();
      cycle();
      chk("end_busy", busy, 0);
   endtask

   org_t e;
   int   base;

   initial begin
      n_vec = 0;
      n_err = 0;
      for (int yy = 0; yy <= int'(ImgH - Win); yy += Step) begin
         for (int xx = 0; xx <= int'(ImgW - Win); xx += Step) begin
            e.x = 16'(xx);
            e.y = 16'(yy);
            olist.push_back(e);
         end
      end
      model_reset();
      idle_inputs();
      rst_n = 0;
      repeat (3) @(posedge clock);
      #1;
      chk_reset_values();
      rst_n = 1;
      cycle();

      // In-flight cap, then full-throughput face routing.
      begin_scan();
      for (int i = 0; i < 8; i++) begin
         win_ready = 1; res_valid = 0;
         cycle();
      end
      chk("cap_xfers", n_xfer_obs, 4);
      chk("cap_win_valid_low", win_valid, 0);
      base = n_xfer_obs;
      res_valid = 1; res_face = head_is(2) || head_is(7); face_ready = 1;
      cycle();
      for (int i = 0; i < 5; i++) begin
         res_valid = 0; face_ready = 1;
         cycle();
      end
      chk("cap_one_more", n_xfer_obs - base, 1);
      run_to_idle(0, 100);
      chk("route_xfers", n_xfer_obs, 9);
      chk("route_done_pulses", n_done_obs, 1);
      chk("route_faces", got_faces.size(), 2);
      if (got_faces.size() == 2) begin
         chk("route_face0", got_faces[0], {16'd2, 16'd0});
         chk("route_face1", got_faces[1], {16'd1, 16'd2});
      end
`ifdef VJ_SCAN_STATS_EN
      chk("route_face_count", face_count, 2);
`endif

      // Output overflow: consumer stalled, every window a face.
      begin_scan();
      for (int i = 0; i < 300 && ph != MFlush; i++) begin
         set_inputs(1);
         cycle();
      end
      for (int i = 0; i < 10; i++) begin
         set_inputs(1);
         cycle();
      end
      chk("ovf_flag", overflow, 1);
      chk("ovf_face_valid", face_valid, 1);
      chk("ovf_busy_in_flush", busy, 1);
      chk("ovf_done_low", n_done_obs, 0);
`ifdef VJ_SCAN_STATS_EN
      chk("ovf_drop_count", drop_count, 7);
`endif
      run_to_idle(0, 50);
      chk("ovf_faces_drained", got_faces.size(), 2);
      chk("ovf_done_pulses", n_done_obs, 1);

      // Handshake stall: win_ready toggles; same raster order must result.
      begin_scan();
      win_ready = 1;
      run_to_idle(2, 400);
      chk("stall_xfers", n_xfer_obs, 9);
      chk("stall_done_pulses", n_done_obs, 1);

      // Reset mid-scan after 5 transfers.
      begin_scan();
      for (int i = 0; i < 200 && n_xfer_obs < 5; i++) begin
         start = 0; win_ready = 1; res_valid = 1'($urandom_range(0, 1));
         res_face = 1; face_ready = 0;
         cycle();
      end
      chk("pre_rst_xfers", n_xfer_obs, 5);
      rst_n = 0;
      #2;
      chk_reset_values();
      model_reset();
      idle_inputs();
      @(posedge clock);
      #1;
      chk_reset_values();
      rst_n = 1;
      cycle();
      chk("post_rst_no_done", n_done_obs, 0);
      begin_scan();
      run_to_idle(3, 600);
      chk("rescan_xfers", n_xfer_obs, 9);
      chk("rescan_done_pulses", n_done_obs, 1);

      // A few fully random scans.
      for (int k = 0; k < 4; k++) begin
         begin_scan();
         run_to_idle(3, 600);
         chk("rand_xfers", n_xfer_obs, 9);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
